// File: rtl/pim_mac_sequencer_if.sv
// rtl/pim_mac_sequencer_if.sv - host request/response and CFU command/response channels
interface pim_host_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 10
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [AWIDTH-3:0] req_addr;
    logic [DWIDTH-1:0] req_data;
    logic [5:0]        req_nbits;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DWIDTH-1:0] rsp_data;
    logic              rsp_err;

    modport master (
        output req_valid, req_op, req_addr, req_data, req_nbits, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );
    modport slave (
        input  req_valid, req_op, req_addr, req_data, req_nbits, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

interface pim_cfu_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 10
);
    logic              cfu_cmd_valid;
    logic              cfu_cmd_ready;
    logic [AWIDTH-1:0] cfu_function_id;
    logic [DWIDTH-1:0] cfu_inputs_0;
    logic [DWIDTH-1:0] cfu_inputs_1;
    logic              cfu_rsp_valid;
    logic              cfu_rsp_ready;
    logic [DWIDTH-1:0] cfu_rsp_data;

    modport master (
        output cfu_cmd_valid, cfu_function_id, cfu_inputs_0, cfu_inputs_1, cfu_rsp_ready,
        input  cfu_cmd_ready, cfu_rsp_valid, cfu_rsp_data
    );
    modport slave (
        input  cfu_cmd_valid, cfu_function_id, cfu_inputs_0, cfu_inputs_1, cfu_rsp_ready,
        output cfu_cmd_ready, cfu_rsp_valid, cfu_rsp_data
    );
endinterface

// File: rtl/pim_mac_sequencer.sv
// rtl/pim_mac_sequencer.sv - expands one host request into CFU command beats, returns one response
module pim_mac_sequencer #(
    parameter int DWIDTH     = 32,
    parameter int AWIDTH     = 10,
    parameter int READ_BEATS = 3,
    parameter int MAC_FLUSH  = 3,
    parameter int TIMEOUT    = 255
) (
    input  logic       clk,
    input  logic       reset,
    pim_host_if.slave  host,
    pim_cfu_if.master  cfu
);
    localparam int SW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [6:0]        beat_cnt_q, beat_cnt_d;
    logic [6:0]        beat_last_q, beat_last_d;
    logic [SW-1:0]     stall_q, stall_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic [AWIDTH-1:0] fid_q, fid_d;
    logic [DWIDTH-1:0] in0_q, in0_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DWIDTH-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
    logic              req_bad;

    assign req_bad = (host.req_op == 2'b11) ||
                     ((host.req_op == 2'b10) &&
                      ((host.req_nbits == 6'd0) || (host.req_nbits > 6'd32)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            beat_cnt_q  <= '0;
            beat_last_q <= '0;
            stall_q     <= '0;
            cmd_valid_q <= 1'b0;
            fid_q       <= '0;
            in0_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            beat_last_q <= beat_last_d;
            stall_q     <= stall_d;
            cmd_valid_q <= cmd_valid_d;
            fid_q       <= fid_d;
            in0_q       <= in0_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        beat_last_d = beat_last_q;
        stall_d     = stall_q;
        cmd_valid_d = cmd_valid_q;
        fid_d       = fid_q;
        in0_d       = in0_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (host.req_valid) begin
                    rsp_data_d = '0;
                    if (req_bad) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d     = S_ISSUE;
                        cmd_valid_d = 1'b1;
                        beat_cnt_d  = '0;
                        stall_d     = '0;
                        fid_d       = {host.req_addr, host.req_op == 2'b10, host.req_op == 2'b00};
                        in0_d       = (host.req_op == 2'b00) ? host.req_data : '0;
                        case (host.req_op)
                            2'b00:   beat_last_d = 7'd0;
                            2'b01:   beat_last_d = 7'(READ_BEATS - 1);
                            default: beat_last_d = 7'(host.req_nbits) + 7'(MAC_FLUSH - 1);
                        endcase
                    end
                end
            end
            S_ISSUE: begin
                if (cfu.cfu_cmd_ready) begin
                    stall_d = '0;
                    if (beat_cnt_q == beat_last_q) begin
                        // only the final beat's CFU output is meaningful to the host
                        state_d     = S_RESP;
                        cmd_valid_d = 1'b0;
                        fid_d       = '0;
                        in0_d       = '0;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b0;
                        if (cfu.cfu_rsp_valid) begin
                            rsp_data_d = cfu.cfu_rsp_data;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + 7'd1;
                    end
                end else if (stall_q == SW'(TIMEOUT - 1)) begin
                    state_d     = S_RESP;
                    cmd_valid_d = 1'b0;
                    fid_d       = '0;
                    in0_d       = '0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_data_d  = '0;
                end else begin
                    stall_d = stall_q + SW'(1);
                end
            end
            S_RESP: begin
                if (host.rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign host.req_ready      = (state_q == S_IDLE);
    assign host.rsp_valid      = rsp_valid_q;
    assign host.rsp_data       = rsp_data_q;
    assign host.rsp_err        = rsp_err_q;
    assign cfu.cfu_cmd_valid   = cmd_valid_q;
    assign cfu.cfu_function_id = fid_q;
    assign cfu.cfu_inputs_0    = in0_q;
    assign cfu.cfu_inputs_1    = '0;
    assign cfu.cfu_rsp_ready   = cmd_valid_q;
endmodule

// File: tb/tb_pim_mac_sequencer.sv
// tb/tb_pim_mac_sequencer.sv - table-driven scoreboard bench for pim_mac_sequencer
module tb_pim_mac_sequencer;
    localparam int DW   = 32;
    localparam int AW   = 10;
    localparam int FLSH = 3;
    localparam int TMO  = 255;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    pim_host_if #(.DWIDTH(DW), .AWIDTH(AW)) host ();
    pim_cfu_if  #(.DWIDTH(DW), .AWIDTH(AW)) cfu ();

    pim_mac_sequencer #(
        .DWIDTH(DW), .AWIDTH(AW), .READ_BEATS(3), .MAC_FLUSH(FLSH), .TIMEOUT(TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .host  (host),
        .cfu   (cfu)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        int            beats;
        int            lat;
    } exp_t;

    typedef struct {
        logic [1:0]    op;
        logic [7:0]    addr;
        logic [DW-1:0] data;
        logic [5:0]    nbits;
        int            mode;
        logic          err;
        int            beats;
        int            hold;
    } vec_t;

    exp_t          sb[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            ready_mode = 0;
    int            beats_seen = 0;
    int            beat_bad = 0;
    int            stall_seen = 0;
    logic [AW-1:0] exp_fid = '0;
    logic [DW-1:0] exp_in0 = '0;
    logic [DW-1:0] mem [256];

    // CFU model: reads return the row only from beat index 2 on, earlier beats are junk
    function automatic logic [DW-1:0] cfu_out(input logic [AW-1:0] fid, input int idx);
        if (fid[1])      return 32'hA500_0000 | 32'(idx);
        else if (fid[0]) return 32'h5A5A_0000 | 32'(idx);
        else if (idx >= 2) return mem[fid[9:2]];
        else             return 32'hBAD0_0000 | 32'(idx);
    endfunction

    function automatic logic [DW-1:0] model_data(input logic [1:0] op, input logic [7:0] addr,
                                                 input logic [5:0] nbits);
        if (op == 2'b00)      return 32'h5A5A_0000;
        else if (op == 2'b01) return mem[addr];
        else                  return 32'hA500_0000 | (32'(nbits) + 32'(FLSH - 1));
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        int k;
        bit tog;
        k = 0;
        tog = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        cfu.cfu_cmd_ready = 1'b1;
        cfu.cfu_rsp_valid = 1'b1;
        cfu.cfu_rsp_data  = '0;
        forever begin
            @(negedge clk);
            case (ready_mode)
                0:       cfu.cfu_cmd_ready = 1'b1;
                1:       begin tog = ~tog; cfu.cfu_cmd_ready = tog; end
                default: cfu.cfu_cmd_ready = 1'b0;
            endcase
            if (!cfu.cfu_cmd_valid) k = 0;
            cfu.cfu_rsp_data = cfu_out(cfu.cfu_function_id, k);
            if (cfu.cfu_cmd_valid) begin
                if (cfu.cfu_cmd_ready) begin
                    beats_seen++;
                    if (cfu.cfu_function_id !== exp_fid || cfu.cfu_inputs_0 !== exp_in0 ||
                        cfu.cfu_inputs_1 !== '0 || cfu.cfu_rsp_ready !== 1'b1)
                        beat_bad++;
                    if (cfu.cfu_function_id[1:0] == 2'b01)
                        mem[cfu.cfu_function_id[9:2]] = cfu.cfu_inputs_0;
                    k++;
                end else begin
                    stall_seen++;
                end
            end
        end
    end

    task automatic do_req(input vec_t v);
        exp_t e;
        int   lat;
        bit   got;
        int   b0, s0, bb0;
        ready_mode = v.mode;
        exp_fid = {v.addr, v.op == 2'b10, v.op == 2'b00};
        exp_in0 = (v.op == 2'b00) ? v.data : '0;
        e.data  = v.err ? '0 : model_data(v.op, v.addr, v.nbits);
        e.err   = v.err;
        e.beats = v.beats;
        e.lat   = v.beats + 1;
        sb.push_back(e);
        for (int c = 0; c < 50 && !host.req_ready; c++) tick();
        b0  = beats_seen;
        s0  = stall_seen;
        bb0 = beat_bad;
        host.rsp_ready = (v.hold == 0);
        host.req_valid = 1'b1;
        host.req_op    = v.op;
        host.req_addr  = v.addr;
        host.req_data  = v.data;
        host.req_nbits = v.nbits;
        lat = 0;
        got = 1'b0;
        for (int c = 0; c < 2000 && !got; c++) begin
            tick();
            lat++;
            host.req_valid = 1'b0;
            got = host.rsp_valid;
        end
        e = sb.pop_front();
        check("rsp_seen", 32'(got), 32'd1);
        if (got) begin
            check("rsp_data", host.rsp_data, e.data);
            check("rsp_err", 32'(host.rsp_err), 32'(e.err));
            check("beat_count", 32'(beats_seen - b0), 32'(e.beats));
            check("beat_fields", 32'(beat_bad - bb0), 32'd0);
            if (v.mode == 0) check("latency", 32'(lat), 32'(e.lat));
            if (v.mode == 2) check("stall_cycles", 32'(stall_seen - s0), 32'(TMO));
            for (int h = 0; h < v.hold; h++) begin
                host.req_valid = 1'b1;
                host.req_op    = 2'b00;
                tick();
                check("hold_valid", 32'(host.rsp_valid), 32'd1);
                check("hold_data", host.rsp_data, e.data);
                check("hold_err", 32'(host.rsp_err), 32'(e.err));
                check("hold_req_ready", 32'(host.req_ready), 32'd0);
                check("hold_no_cmd", 32'(cfu.cfu_cmd_valid), 32'd0);
            end
            host.req_valid = 1'b0;
            host.rsp_ready = 1'b1;
            tick();
            check("rsp_drop", 32'(host.rsp_valid), 32'd0);
            check("idle_ready", 32'(host.req_ready), 32'd1);
        end
    endtask

    initial begin
        vec_t tbl[15];
        int   b0;
        bit   quiet;
        host.req_valid = 1'b0;
        host.req_op    = 2'b00;
        host.req_addr  = '0;
        host.req_data  = '0;
        host.req_nbits = '0;
        host.rsp_ready = 1'b1;
        reset = 1'b0;
        tick();
        tick();
        check("rst_req_ready", 32'(host.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(host.rsp_valid), 32'd0);
        check("rst_rsp_err", 32'(host.rsp_err), 32'd0);
        check("rst_rsp_data", host.rsp_data, 32'd0);
        check("rst_cmd_valid", 32'(cfu.cfu_cmd_valid), 32'd0);
        check("rst_fid", 32'(cfu.cfu_function_id), 32'd0);
        check("rst_in0", cfu.cfu_inputs_0, 32'd0);
        reset = 1'b1;
        tick();

        //            op     addr    data           nbits  mode err  beats hold
        tbl[0]  = '{2'b00, 8'd5,   32'hDEADBEEF, 6'd0,  0, 1'b0, 1,  0};
        tbl[1]  = '{2'b01, 8'd5,   32'h0,        6'd0,  0, 1'b0, 3,  0};
        tbl[2]  = '{2'b10, 8'd0,   32'h0,        6'd8,  0, 1'b0, 11, 0};
        tbl[3]  = '{2'b10, 8'd0,   32'h0,        6'd0,  0, 1'b1, 0,  0};
        tbl[4]  = '{2'b11, 8'd5,   32'h0,        6'd8,  0, 1'b1, 0,  0};
        tbl[5]  = '{2'b10, 8'd1,   32'h0,        6'd33, 0, 1'b1, 0,  0};
        tbl[6]  = '{2'b10, 8'd2,   32'h0,        6'd32, 0, 1'b0, 35, 0};
        tbl[7]  = '{2'b10, 8'd4,   32'h0,        6'd1,  0, 1'b0, 4,  0};
        tbl[8]  = '{2'b00, 8'd3,   32'h12345678, 6'd0,  1, 1'b0, 1,  0};
        tbl[9]  = '{2'b01, 8'd3,   32'h0,        6'd0,  1, 1'b0, 3,  0};
        tbl[10] = '{2'b10, 8'd7,   32'h0,        6'd8,  1, 1'b0, 11, 0};
        tbl[11] = '{2'b01, 8'd9,   32'h0,        6'd0,  2, 1'b1, 0,  0};
        tbl[12] = '{2'b01, 8'd5,   32'h0,        6'd0,  0, 1'b0, 3,  4};
        tbl[13] = '{2'b00, 8'd200, 32'hCAFEF00D, 6'd0,  0, 1'b0, 1,  0};
        tbl[14] = '{2'b01, 8'd200, 32'h0,        6'd0,  0, 1'b0, 3,  0};
        for (int i = 0; i < 15; i++) do_req(tbl[i]);

        // abort a MAC in the middle of its fourth beat
        ready_mode = 0;
        exp_fid = {8'd0, 2'b10};
        exp_in0 = '0;
        b0 = beats_seen;
        host.req_valid = 1'b1;
        host.req_op    = 2'b10;
        host.req_addr  = 8'd0;
        host.req_nbits = 6'd8;
        for (int c = 0; c < 100 && (beats_seen - b0) < 4; c++) begin
            tick();
            host.req_valid = 1'b0;
        end
        check("mid_mac_beats", 32'(beats_seen - b0), 32'd4);
        reset = 1'b0;
        #1;
        check("mid_rst_req_ready", 32'(host.req_ready), 32'd1);
        check("mid_rst_rsp_valid", 32'(host.rsp_valid), 32'd0);
        check("mid_rst_rsp_err", 32'(host.rsp_err), 32'd0);
        check("mid_rst_rsp_data", host.rsp_data, 32'd0);
        check("mid_rst_cmd_valid", 32'(cfu.cfu_cmd_valid), 32'd0);
        check("mid_rst_fid", 32'(cfu.cfu_function_id), 32'd0);
        tick();
        reset = 1'b1;
        quiet = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (cfu.cfu_cmd_valid || host.rsp_valid || !host.req_ready) quiet = 1'b0;
        end
        check("abort_silent", 32'(quiet), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
